// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the debounce bank.
//   DEB_STABLE_10MS_50M : stable-cycle count for a 10 ms filter at 50 MHz
//   DEB_RPT_DLY_DEF     : default hold time before the first auto-repeat pulse
//   DEB_RPT_PER_DEF     : default spacing between later auto-repeat pulses
//   deb_cw(n)           : counter width for a count of n, never less than 1
package debounce_pkg;

   localparam int DEB_STABLE_10MS_50M = 500000;
   localparam int DEB_RPT_DLY_DEF     = 25000000;
   localparam int DEB_RPT_PER_DEF     = 5000000;

   function automatic int deb_cw(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop synchroniser, symmetric stable-count filter,
// registered rise/fall pulses and optional hold auto-repeat.
// Optional feature macro: DEBOUNCE_REPEAT_EN (auto-repeat on rep).
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   data_in   raw asynchronous pin level
//   data_out  debounced level
//   rise      1-cycle pulse when data_out goes 0->1
//   fall      1-cycle pulse when data_out goes 1->0
//   rep       1-cycle auto-repeat pulse while data_out is held 1 (0 without macro)
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int STABLE_CNT = DEB_STABLE_10MS_50M,
   parameter bit ACTIVE_LOW = 1'b0,
   parameter int REPEAT_DLY = DEB_RPT_DLY_DEF,
   parameter int REPEAT_PER = DEB_RPT_PER_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic data_in,
   output logic data_out,
   output logic rise,
   output logic fall,
   output logic rep
);

   localparam int            CW       = deb_cw(STABLE_CNT);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

   logic          sync_a;
   logic          sync_b;
   logic [CW-1:0] cnt;
   logic          accept;

   // The new level has been seen for STABLE_CNT consecutive cycles.
   assign accept = (sync_b != data_out) && (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_a   <= 1'b0;
         sync_b   <= 1'b0;
         cnt      <= '0;
         data_out <= 1'b0;
         rise     <= 1'b0;
         fall     <= 1'b0;
      end else begin
         sync_a <= data_in ^ ACTIVE_LOW;
         sync_b <= sync_a;
         // Any return to the current level restarts the count; the accept
         // cycle also clears it, so the counter can never wrap.
         if (sync_b == data_out || accept) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
         if (accept) begin
            data_out <= sync_b;
         end
         rise <= accept & sync_b;
         fall <= accept & ~sync_b;
      end
   end

`ifdef DEBOUNCE_REPEAT_EN
   localparam int            RW       = deb_cw((REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER);
   localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DLY - 1);
   localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PER - 1);

   logic [RW-1:0] rcnt;
   logic          rfirst;
   logic          rhit;

   // rfirst selects the initial hold delay; later pulses use the period.
   assign rhit = (rcnt == (rfirst ? DLY_LAST : PER_LAST));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rcnt   <= '0;
         rfirst <= 1'b1;
         rep    <= 1'b0;
      end else if (!data_out || accept) begin
         // Released, rising (rcnt is 0 during the rise cycle) or falling:
         // a fall suppresses any pulse in the same cycle.
         rcnt   <= '0;
         rfirst <= 1'b1;
         rep    <= 1'b0;
      end else if (rhit) begin
         rcnt   <= '0;
         rfirst <= 1'b0;
         rep    <= 1'b1;
      end else begin
         rcnt <= rcnt + 1'b1;
         rep  <= 1'b0;
      end
   end
`else
   logic [31:0] rpt_unused;
   assign rpt_unused = REPEAT_DLY + REPEAT_PER;
   assign rep        = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// N-channel switch/button debouncer; every channel is independent and all
// outputs are in the clk domain.
// Optional feature macro: DEBOUNCE_REPEAT_EN (per-channel hold auto-repeat;
// without it rep is constant 0 and REPEAT_* are ignored).
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   data_in   [CH] raw asynchronous pin levels
//   data_out  [CH] debounced levels
//   rise      [CH] 1-cycle pulse when data_out goes 0->1
//   fall      [CH] 1-cycle pulse when data_out goes 1->0
//   rep       [CH] 1-cycle auto-repeat pulse while data_out held 1
module debounce_bank
   import debounce_pkg::*;
#(
   parameter int CH         = 4,
   parameter int STABLE_CNT = DEB_STABLE_10MS_50M,
   parameter int ACTIVE_LOW = 0,
   parameter int REPEAT_DLY = DEB_RPT_DLY_DEF,
   parameter int REPEAT_PER = DEB_RPT_PER_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [CH-1:0] data_in,
   output logic [CH-1:0] data_out,
   output logic [CH-1:0] rise,
   output logic [CH-1:0] fall,
   output logic [CH-1:0] rep
);

   localparam bit INV = (ACTIVE_LOW != 0);

   for (genvar i = 0; i < CH; i++) begin : g_ch
      debounce_channel #(
         .STABLE_CNT (STABLE_CNT),
         .ACTIVE_LOW (INV),
         .REPEAT_DLY (REPEAT_DLY),
         .REPEAT_PER (REPEAT_PER)
      ) u_ch (
         .clk      (clk),
         .rst_n    (rst_n),
         .data_in  (data_in[i]),
         .data_out (data_out[i]),
         .rise     (rise[i]),
         .fall     (fall[i]),
         .rep      (rep[i])
      );
   end

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank (CH=2, STABLE_CNT=4, REPEAT_DLY=10,
// REPEAT_PER=3). Expected output vectors are queued per cycle when stimulus
// is driven and compared on the falling edge of the matching cycle.
module tb_debounce_bank;

   localparam int RPT_DLY = 10;
   localparam int RPT_PER = 3;
   localparam int LAT     = 6;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic [1:0] data_in = 2'b11;
   logic [1:0] data_out;
   logic [1:0] rise;
   logic [1:0] fall;
   logic [1:0] rep;

   int cyc   = 0;
   int total = 0;
   int bad   = 0;

   typedef struct {
      int         cyc;
      logic [7:0] v;
      string      tag;
   } sb_t;

   sb_t        sb[$];
   logic [1:0] cur = 2'b00;
   int         rise_cyc[2] = '{-1, -1};

   debounce_bank #(
      .CH         (2),
      .STABLE_CNT (4),
      .ACTIVE_LOW (0),
      .REPEAT_DLY (RPT_DLY),
      .REPEAT_PER (RPT_PER)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .data_in  (data_in),
      .data_out (data_out),
      .rise     (rise),
      .fall     (fall),
      .rep      (rep)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_to(input int t);
      while (cyc < t) tick();
   endtask

   function automatic logic [1:0] rep_at(input int c);
      logic [1:0] r;
      r = 2'b00;
`ifdef DEBOUNCE_REPEAT_EN
      for (int ch = 0; ch < 2; ch++) begin
         if (rise_cyc[ch] >= 0 && (c - rise_cyc[ch]) >= RPT_DLY &&
             ((c - rise_cyc[ch] - RPT_DLY) % RPT_PER) == 0)
            r[ch] = 1'b1;
      end
`endif
      return r;
   endfunction

   task automatic push(input int c, input logic [1:0] r, input logic [1:0] f, input string tag);
      sb_t e;
      e.cyc = c;
      e.v   = {cur, r, f, rep_at(c)};
      e.tag = tag;
      sb.push_back(e);
   endtask

   // Input changed just after cycle n: the new level appears at cycle n+LAT.
   task automatic push_step(input int n, input logic [1:0] newv, input int hold, input string tag);
      logic [1:0] r;
      logic [1:0] f;
      for (int k = 1; k < LAT; k++) push(n + k, 2'b00, 2'b00, tag);
      r = newv & ~cur;
      f = ~newv & cur;
      for (int ch = 0; ch < 2; ch++) begin
         if (r[ch]) rise_cyc[ch] = n + LAT;
         if (f[ch]) rise_cyc[ch] = -1;
      end
      cur = newv;
      push(n + LAT, r, f, {tag, "_edge"});
      for (int k = LAT + 1; k <= hold; k++) push(n + k, 2'b00, 2'b00, tag);
   endtask

   task automatic step(input logic [1:0] newv, input int hold, input string tag);
      int n;
      n = cyc;
      data_in = newv;
      push_step(n, newv, hold, tag);
      wait_to(n + hold);
   endtask

   task automatic drive_hold(input logic [1:0] v, input int len, input string tag);
      int n;
      n = cyc;
      data_in = v;
      for (int k = 1; k <= len; k++) push(n + k, 2'b00, 2'b00, tag);
      wait_to(n + len);
   endtask

   task automatic reset_pulse(input int len, input string tag);
      rst_n = 1'b0;
      #1;
      check({tag, "_async"}, 32'({data_out, rise, fall, rep}), 32'd0);
      cur = 2'b00;
      rise_cyc[0] = -1;
      rise_cyc[1] = -1;
      repeat (len) tick();
      check({tag, "_held"}, 32'({data_out, rise, fall, rep}), 32'd0);
   endtask

   task automatic release_expect(input int hold, input string tag);
      int n;
      rst_n = 1'b1;
      n = cyc;
      check({tag, "_rel"}, 32'({data_out, rise, fall, rep}), 32'd0);
      push_step(n, data_in, hold, tag);
      wait_to(n + hold);
   endtask

   always @(negedge clk) begin
      sb_t e;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         if (e.cyc == cyc)
            check(e.tag, 32'({data_out, rise, fall, rep}), 32'(e.v));
         else
            check({e.tag, "_late"}, cyc, e.cyc);
      end
   end

   initial begin
      // 1: power-on reset with both pins high
      repeat (3) tick();
      check("por_out", 32'({data_out, rise, fall, rep}), 32'd0);
      release_expect(10, "t1_por");

      // 2: single-channel press / release on ch0
      step(2'b10, 10, "t2_pre");
      step(2'b11, 10, "t2_rise");
      step(2'b10, 10, "t2_fall");

      // 3: 3-cycle glitches separated by 1-cycle lows never pass
      for (int r = 0; r < 5; r++) begin
         drive_hold(2'b11, 3, "t3_glitch");
         drive_hold(2'b10, 1, "t3_gap");
      end
      drive_hold(2'b10, 8, "t3_settle");

      // 4: ch0 press and ch1 release on the same edge
      step(2'b01, 10, "t4_cross");

      // 5: hold ch0 (auto-repeat when enabled), then release
      drive_hold(2'b01, 20, "t5_hold");
      step(2'b00, 20, "t5_release");

      // 6: reset mid-count, then mid-hold; full latency after each release
      drive_hold(2'b01, 4, "t6_midcnt");
      reset_pulse(2, "t6_rst_cnt");
      release_expect(12, "t6_relat");
      drive_hold(2'b01, 4, "t6_hold");
      reset_pulse(2, "t6_rst_hold");
      release_expect(12, "t6_relat2");

      for (int i = 0; i < 50 && sb.size() > 0; i++) tick();
      check("sb_drain", sb.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
